// File: rtl/adder_tree_acc_if.sv
// Bundles the adder_tree_acc vector input, frame controls and result outputs.
// Latency: none; this is wiring only.
// Backpressure: none; iena/oena are one-way strobes, and the producer never stalls.
//
// Ports (all signals are seen from the producer side):
//   iena/idat        input vector strobe and signed elements
//   iacc_len/ishift  frame length minus one, and output right-shift
//   oena/odat/osat/osum  result strobe, scaled/saturated sum, saturation flag, raw sum
interface adder_tree_acc_if #(
    parameter int pDAT_W   = 12,
    parameter int pDAT_Num = 2048,
    parameter int pACC_MAX = 16,
    parameter int pOUT_W   = 16
);
    localparam int cS     = $clog2(pDAT_Num);
    localparam int cSUM_W = pDAT_W + cS;
    localparam int cLEN_W = $clog2(pACC_MAX);
    localparam int cACC_W = cSUM_W + cLEN_W;
    localparam int cSH_W  = $clog2(cACC_W);

    logic                     iena;
    logic signed [pDAT_W-1:0] idat [pDAT_Num];
    logic [cLEN_W-1:0]        iacc_len;
    logic [cSH_W-1:0]         ishift;
    logic                     oena;
    logic signed [pOUT_W-1:0] odat;
    logic                     osat;
    logic signed [cACC_W-1:0] osum;

    modport master (
        output iena, idat, iacc_len, ishift,
        input  oena, odat, osat, osum
    );

    modport slave (
        input  iena, idat, iacc_len, ishift,
        output oena, odat, osat, osum
    );
endinterface

// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree, frame accumulator, rounding shift and saturation.
// Latency: the last vector of a frame at cycle t gives oena at t+cS+2.
// Backpressure: none; accepts one vector per cycle, and gaps of any length are allowed.
//
// Ports: iclk clock; irst synchronous active-high reset; bus (slave modport):
//   iena/idat in, iacc_len/ishift in (latched at the start of a frame),
//   oena/odat/osat/osum out (odat/osat/osum hold their values between strobes).
module adder_tree_acc #(
    parameter int pDAT_W   = 12,
    parameter int pDAT_Num = 2048,
    parameter int pACC_MAX = 16,
    parameter int pOUT_W   = 16
) (
    input  logic             iclk,
    input  logic             irst,
    adder_tree_acc_if.slave  bus
);
    localparam int cS     = $clog2(pDAT_Num);
    localparam int cSUM_W = pDAT_W + cS;
    localparam int cLEN_W = $clog2(pACC_MAX);
    localparam int cACC_W = cSUM_W + cLEN_W;
    localparam int cSH_W  = $clog2(cACC_W);

    // Number of results produced by tree stage k (inputs are halved, rounding up).
    function automatic int stage_n(input int k);
        int n;
        n = pDAT_Num;
        for (int i = 0; i <= k; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // ---------------- adder tree ----------------
    // Each stage pads its input to an even count with zeros. Each stage also grows
    // the width by one bit, so no result can overflow.
    for (genvar k = 0; k < cS; k++) begin : stg
        localparam int IN_N  = (k == 0) ? pDAT_Num : stage_n(k - 1);
        localparam int OUT_N = stage_n(k);
        localparam int WI    = pDAT_W + k;

        logic signed [WI-1:0] a [2*OUT_N];
        logic signed [WI:0]   s [OUT_N];

        for (genvar i = 0; i < 2*OUT_N; i++) begin : pad
            if (i >= IN_N) begin : g_zero
                assign a[i] = '0;
            end else if (k == 0) begin : g_in
                assign a[i] = bus.idat[i];
            end else begin : g_prev
                assign a[i] = stg[k-1].s[i];
            end
        end

        always_ff @(posedge iclk) begin
            for (int j = 0; j < OUT_N; j++)
                s[j] <= {a[2*j][WI-1], a[2*j]} + {a[2*j+1][WI-1], a[2*j+1]};
        end
    end

    logic signed [cSUM_W-1:0] tree_sum;
    assign tree_sum = stg[cS-1].s[0];

    // The valid bit travels alongside the tree data. Reset empties the pipeline,
    // so vectors that are in flight are dropped.
    logic [cS-1:0] vld_sr;
    logic          tree_vld;
    always_ff @(posedge iclk) begin
        if (irst) vld_sr <= '0;
        else      vld_sr <= cS'({vld_sr, bus.iena});
    end
    assign tree_vld = vld_sr[cS-1];

    // ---------------- frame accumulator ----------------
    logic [cLEN_W-1:0]        cnt, len_q, cur_len;
    logic [cSH_W-1:0]         sh_q, sh_in, cur_sh, fin_sh;
    logic signed [cACC_W-1:0] acc, sum_ext, acc_nxt, fin_q;
    logic                     done;

    // Shifts beyond the accumulator width would only repeat the sign bit.
    assign sh_in   = (int'(bus.ishift) >= cACC_W) ? cSH_W'(cACC_W - 1) : bus.ishift;
    // On the first vector of a frame, the live controls apply. This lets N=1 frames
    // complete in the same cycle that the controls are latched.
    assign cur_len = (cnt == '0) ? bus.iacc_len : len_q;
    assign cur_sh  = (cnt == '0) ? sh_in : sh_q;
    assign sum_ext = cACC_W'(tree_sum);
    assign acc_nxt = (cnt == '0) ? sum_ext : acc + sum_ext;

    always_ff @(posedge iclk) begin
        if (irst) begin
            cnt    <= '0;
            len_q  <= '0;
            sh_q   <= '0;
            acc    <= '0;
            fin_q  <= '0;
            fin_sh <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tree_vld) begin
                if (cnt == '0) begin
                    len_q <= bus.iacc_len;
                    sh_q  <= sh_in;
                end
                if (cnt == cur_len) begin
                    fin_q  <= acc_nxt;
                    fin_sh <= cur_sh;
                    done   <= 1'b1;
                    cnt    <= '0;
                end else begin
                    acc <= acc_nxt;
                    cnt <= cnt + cLEN_W'(1);
                end
            end
        end
    end

    // ---------------- round, shift, saturate ----------------
    // One guard bit keeps the rounding offset from overflowing at the positive extreme.
    localparam logic signed [cACC_W:0] cOMAX = {{(cACC_W-pOUT_W+2){1'b0}}, {(pOUT_W-1){1'b1}}};
    localparam logic signed [cACC_W:0] cOMIN = ~cOMAX;

    logic signed [cACC_W:0]   rnd, biased, shr;
    logic signed [pOUT_W-1:0] sat_dat;
    logic                     sat_flag;

    always_comb begin
        rnd = '0;
        if (fin_sh != '0) rnd[fin_sh - cSH_W'(1)] = 1'b1;
        biased   = {fin_q[cACC_W-1], fin_q} + rnd;
        shr      = biased >>> fin_sh;
        sat_dat  = shr[pOUT_W-1:0];
        sat_flag = 1'b0;
        if (shr > cOMAX) begin
            sat_dat  = {1'b0, {(pOUT_W-1){1'b1}}};
            sat_flag = 1'b1;
        end else if (shr < cOMIN) begin
            sat_dat  = {1'b1, {(pOUT_W-1){1'b0}}};
            sat_flag = 1'b1;
        end
    end

    logic                     oena_q, osat_q;
    logic signed [pOUT_W-1:0] odat_q;
    logic signed [cACC_W-1:0] osum_q;

    always_ff @(posedge iclk) begin
        if (irst) begin
            oena_q <= 1'b0;
            odat_q <= '0;
            osat_q <= 1'b0;
            osum_q <= '0;
        end else begin
            oena_q <= done;
            if (done) begin
                odat_q <= sat_dat;
                osat_q <= sat_flag;
                osum_q <= fin_q;
            end
        end
    end

    assign bus.oena = oena_q;
    assign bus.odat = odat_q;
    assign bus.osat = osat_q;
    assign bus.osum = osum_q;
endmodule

// File: doc/adder_tree_acc.md
Name: adder_tree_acc

Overview:
Pipelined, fully parametrised adder tree that sums a pDAT_Num-element signed vector each valid cycle. Bit growth is full, with no wrap. The tree output feeds a frame accumulator that sums N consecutive valid vectors (N programmable, 1..pACC_MAX). A rounding right-shift and saturation stage follows the accumulator. It sits in the sync path after the correlator multipliers, as the next-generation replacement for the plain power-of-two adder tree.

Parameters:
pDAT_W, 12, input sample width (signed)
pDAT_Num, 2048, number of input elements; any value >= 2, power of two not required
pACC_MAX, 16, maximum vectors accumulated per frame; power of two, >= 2
pOUT_W, 16, output width (signed), 2 <= pOUT_W <= cACC_W
Derived: cS = $clog2(pDAT_Num); cSUM_W = pDAT_W+cS; cLEN_W = $clog2(pACC_MAX); cACC_W = cSUM_W+cLEN_W; cSH_W = $clog2(cACC_W)

Ports:
iclk  in  1  clock
irst  in  1  synchronous reset, active-high
iena  in  1  input vector valid
idat  in  pDAT_W x [0:pDAT_Num-1]  signed input vector
iacc_len  in  cLEN_W  frame length minus one (N = iacc_len+1)
ishift  in  cSH_W  arithmetic right-shift applied to frame sum before saturation
oena  out  1  one-cycle result strobe
odat  out  pOUT_W  signed scaled, saturated frame sum
osat  out  1  saturation occurred on this result; valid with oena
osum  out  cACC_W  unscaled full-precision frame sum; valid with oena

Behaviour:
- Clocking and reset: one clock, iclk. Reset irst is synchronous and active-high.
- Reset values: on irst=1, oena=0, odat=0, osat=0, osum=0, the valid pipeline is cleared, the frame counter is 0 and the accumulator is 0. Tree data registers need no reset. In-flight vectors are discarded: no oena is produced for any vector accepted before or during reset.
- Tree structure: cS registered stages. Stage 0 adds pairs of idat. Element indices >= pDAT_Num read as 0, so odd counts are zero-padded at every stage.
- Tree widths: stage k results are pDAT_W+k+1 bits, sign-extended. No truncation and no overflow is possible.
- Valid pipeline: a cS-deep shift register carries iena alongside the data. Vectors with iena=0 are ignored. Gaps of any length are allowed. Throughput is one vector per cycle.
- Frame counter: cnt counts 0..N-1 on each tree-valid cycle.
  - cnt==0: acc <= sum; iacc_len and ishift are latched as len_q and sh_q. Changes to either mid-frame have no effect until the next frame.
  - cnt<len_q: acc <= acc+sum; cnt++.
  - cnt==len_q: final = acc+sum (or sum when len_q==0); cnt <= 0; final is registered to the output stage with a done flag.
- Output stage (one register):
  - sh_q==0: r = final.
  - sh_q>0: r = (final + 2^(sh_q-1)) >>> sh_q, i.e. round half toward +inf.
  - ishift values >= cACC_W are treated as cACC_W-1.
  - If r > 2^(pOUT_W-1)-1, then odat = max and osat=1. If r < -2^(pOUT_W-1), then odat = min and osat=1. Otherwise odat = r and osat=0.
  - osum = final. oena=1 for exactly one cycle.
- Hold behaviour: odat, osat and osum hold their values between strobes.
- Latency: last iena of a frame at cycle t gives oena at t+cS+2.
- Back-to-back frames: back-to-back frames with N=1 produce oena on every cycle.
- Reset mid-frame: partial acc is dropped; the next valid vector starts a new frame at cnt=0.
- irst asserted in the same cycle as iena: the vector is dropped.

Test Plan:
1. pDAT_Num=8, pDAT_W=8, pOUT_W=12, iacc_len=0, ishift=0. Single iena with all idat=127 at cycle t -> oena at t+5, odat=1016, osum=1016, osat=0.
2. pDAT_Num=5 (zero padding, cS=3), iacc_len=0. idat={1,2,3,4,5} -> odat=15, latency 5. Then idat={-128,-128,-128,-128,-128} -> odat=-640.
3. Accumulation: pDAT_Num=8, iacc_len=3, ishift=0. Four vectors of all 10, with 0,2,0 idle cycles between them -> exactly one oena, 5 cycles after the 4th vector, odat=320. Change iacc_len to 0 after the 2nd vector -> no effect on this frame.
4. Saturation/shift: pDAT_Num=8, pDAT_W=8, pOUT_W=8. All idat=-128, ishift=0 -> odat=-128, osat=1, osum=-1024. Same input with ishift=3 -> odat=-128, osat=0. All idat=127 with ishift=0 -> odat=127, osat=1.
5. Rounding: pDAT_Num=2, pOUT_W=12, ishift=3. idat={6,6} (sum 12) -> odat=2. idat={-6,-6} (sum -12) -> odat=-1. idat={5,5} (sum 10) -> odat=1.
6. Reset mid-frame: iacc_len=3, two vectors of all 1, then irst for one cycle, then four vectors of all 2 -> no oena from the first pair; one oena with odat=8*pDAT_Num... for pDAT_Num=8, odat=64. Streaming: 20 consecutive N=1 vectors -> 20 consecutive oena cycles with matching sums.
